// File: rtl/uc_seq_pkg.sv
// Shared encodings for the control sequencer: opcodes, ALU codes, PC/stack selects, states.
package uc_pkg;

   localparam logic [5:0] ADD  = 6'd0,  SUB  = 6'd1,  MUL  = 6'd2,  DIV  = 6'd3;
   localparam logic [5:0] ADDI = 6'd4,  SUBI = 6'd5,  MULI = 6'd6,  DIVI = 6'd7;
   localparam logic [5:0] MOD  = 6'd8,  OR   = 6'd9,  AND  = 6'd10, SL   = 6'd11;
   localparam logic [5:0] NOT  = 6'd12, SR   = 6'd13, XOR  = 6'd14, JE   = 6'd15;
   localparam logic [5:0] JB   = 6'd16, JA   = 6'd17, JNE  = 6'd18, JBE  = 6'd19;
   localparam logic [5:0] JAE  = 6'd20, JNZ  = 6'd21, JZ   = 6'd22, JMP  = 6'd23;
   localparam logic [5:0] HLT  = 6'd24, PUSH = 6'd25, POP  = 6'd26, NOP  = 6'd27;
   localparam logic [5:0] MOV  = 6'd28, MOVI = 6'd29;
   localparam logic [5:0] OPC_LAST = MOVI;

   localparam logic [5:0] ALU_NONE = 6'd0, ALU_ADD = 6'd1, ALU_SUB = 6'd2, ALU_MUL = 6'd3;
   localparam logic [5:0] ALU_DIV  = 6'd4, ALU_MOD = 6'd5, ALU_OR  = 6'd6, ALU_AND = 6'd7;
   localparam logic [5:0] ALU_SL   = 6'd8, ALU_NOT = 6'd9, ALU_SR  = 6'd10, ALU_XOR = 6'd11;

   localparam logic [4:0] PC_SEQ = 5'd0, PC_JE  = 5'd1, PC_JB  = 5'd2, PC_JA = 5'd3;
   localparam logic [4:0] PC_JNE = 5'd4, PC_JBE = 5'd5, PC_JAE = 5'd6, PC_JNZ = 5'd7;
   localparam logic [4:0] PC_JZ  = 5'd8, PC_JMP = 5'd9, PC_HLT = 5'd10;

   localparam logic [1:0] STK_NONE = 2'd0, STK_PUSH = 2'd1, STK_POP = 2'd2;

   typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_WAIT_ALU, ST_HALT} state_t;

endpackage

// File: rtl/uc_seq_if.sv
// Instruction handshake plus decoded control bundle between fetch side and uc_seq.
interface uc_seq_if #(
   parameter int unsigned INSTR_W = 32,
   parameter int unsigned REG_W   = 3,
   parameter int unsigned IMM_W   = 21,
   parameter int unsigned ALU_W   = 6
);
   logic [INSTR_W-1:0] instr;
   logic               instr_valid;
   logic               instr_ready;
   logic               alu_done;
   logic               resume;
   logic               ctrl_valid;
   logic [ALU_W-1:0]   alucode;
   logic               imControl;
   logic               writecode;
   logic [4:0]         pcControl;
   logic [1:0]         stackSelect;
   logic [REG_W-1:0]   op1;
   logic [IMM_W-1:0]   op2;
   logic               flag;
   logic               flag1;
   logic               halted;
   logic               illegal;

   modport master (
      output instr, instr_valid, alu_done, resume,
      input  instr_ready, ctrl_valid, alucode, imControl, writecode, pcControl,
             stackSelect, op1, op2, flag, flag1, halted, illegal
   );

   modport slave (
      input  instr, instr_valid, alu_done, resume,
      output instr_ready, ctrl_valid, alucode, imControl, writecode, pcControl,
             stackSelect, op1, op2, flag, flag1, halted, illegal
   );
endinterface

// File: rtl/uc_seq_decode.sv
// Pure combinational opcode decoder feeding the registered sequencer.
module uc_decode
   import uc_pkg::*;
(
   input  logic [5:0] opc,
   output logic [5:0] alucode,
   output logic       imControl,
   output logic       writecode,
   output logic [4:0] pcControl,
   output logic [1:0] stackSelect,
   output logic       mc_op,
   output logic       hlt_op,
   output logic       illegal
);
   always_comb begin
      alucode     = ALU_NONE;
      imControl   = 1'b0;
      writecode   = 1'b0;
      pcControl   = PC_SEQ;
      stackSelect = STK_NONE;
      mc_op       = 1'b0;
      hlt_op      = 1'b0;
      illegal     = (opc > OPC_LAST);
      case (opc)
         ADD:  alucode = ALU_ADD;
         SUB:  alucode = ALU_SUB;
         MUL:  begin alucode = ALU_MUL; mc_op = 1'b1; end
         DIV:  begin alucode = ALU_DIV; mc_op = 1'b1; end
         ADDI: begin alucode = ALU_ADD; imControl = 1'b1; end
         SUBI: begin alucode = ALU_SUB; imControl = 1'b1; end
         MULI: begin alucode = ALU_MUL; imControl = 1'b1; mc_op = 1'b1; end
         DIVI: begin alucode = ALU_DIV; imControl = 1'b1; mc_op = 1'b1; end
         MOD:  begin alucode = ALU_MOD; mc_op = 1'b1; end
         OR:   alucode = ALU_OR;
         AND:  alucode = ALU_AND;
         SL:   alucode = ALU_SL;
         NOT:  alucode = ALU_NOT;
         SR:   alucode = ALU_SR;
         XOR:  alucode = ALU_XOR;
         JE:   pcControl = PC_JE;
         JB:   pcControl = PC_JB;
         JA:   pcControl = PC_JA;
         JNE:  pcControl = PC_JNE;
         JBE:  pcControl = PC_JBE;
         JAE:  pcControl = PC_JAE;
         JNZ:  pcControl = PC_JNZ;
         JZ:   pcControl = PC_JZ;
         JMP:  pcControl = PC_JMP;
         HLT:  begin pcControl = PC_HLT; hlt_op = 1'b1; end
         PUSH: stackSelect = STK_PUSH;
         POP:  begin stackSelect = STK_POP; writecode = 1'b1; end
         MOV:  writecode = 1'b1;
         MOVI: begin writecode = 1'b1; imControl = 1'b1; end
         default: ;
      endcase
   end
endmodule

// File: rtl/uc_seq.sv
// Registered, handshaked control sequencer: issues one decoded instruction per transfer,
// stalls on multi-cycle ALU ops until alu_done and parks on HLT until resume.
module uc_seq
   import uc_pkg::*;
#(
   parameter int unsigned INSTR_W    = 32,
   parameter int unsigned OPC_W      = 6,
   parameter int unsigned REG_W      = 3,
   parameter int unsigned IMM_W      = 21,
   parameter int unsigned ALU_W      = 6,
   parameter bit          MULTICYCLE = 1'b1
) (
   input logic     clock,
   input logic     resetn,
   uc_seq_if.slave bus
);
   state_t           state;
   logic             busy, cur_mc, cur_hlt, xfer, clear, mc_eff;
   logic [OPC_W-1:0] opc;
   logic [5:0]       d_alu;
   logic [4:0]       d_pc;
   logic [1:0]       d_stk;
   logic             d_im, d_wr, d_mc, d_hlt, d_ill;

   assign opc = bus.instr[INSTR_W-1 -: OPC_W];

   uc_decode u_decode (
      .opc         (opc),
      .alucode     (d_alu),
      .imControl   (d_im),
      .writecode   (d_wr),
      .pcControl   (d_pc),
      .stackSelect (d_stk),
      .mc_op       (d_mc),
      .hlt_op      (d_hlt),
      .illegal     (d_ill)
   );

   assign mc_eff = d_mc & MULTICYCLE;

   // busy is registered; the resetn gate keeps ready low only while reset is held
   assign bus.instr_ready = resetn & ~busy;
   assign xfer            = bus.instr_valid & bus.instr_ready;

   always_comb begin
      clear = !xfer && ((state == ST_EXEC && !cur_mc && !cur_hlt) ||
                        (state == ST_WAIT_ALU && bus.alu_done) ||
                        (state == ST_HALT && bus.resume));
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state      <= ST_IDLE;
         busy       <= 1'b0;
         cur_mc     <= 1'b0;
         cur_hlt    <= 1'b0;
         bus.halted <= 1'b0;
      end else if (xfer) begin
         state      <= ST_EXEC;
         busy       <= mc_eff | d_hlt;
         cur_mc     <= mc_eff;
         cur_hlt    <= d_hlt;
         bus.halted <= 1'b0;
      end else begin
         case (state)
            ST_EXEC: begin
               if (cur_mc) begin
                  state <= ST_WAIT_ALU;
               end else if (cur_hlt) begin
                  state      <= ST_HALT;
                  bus.halted <= 1'b1;
               end else begin
                  state <= ST_IDLE;
               end
            end
            ST_WAIT_ALU: if (bus.alu_done) begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
            ST_HALT: if (bus.resume) begin
               state      <= ST_IDLE;
               busy       <= 1'b0;
               bus.halted <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         bus.ctrl_valid  <= 1'b0;
         bus.illegal     <= 1'b0;
         bus.alucode     <= '0;
         bus.imControl   <= 1'b0;
         bus.writecode   <= 1'b0;
         bus.pcControl   <= '0;
         bus.stackSelect <= '0;
         bus.op1         <= '0;
         bus.op2         <= '0;
         bus.flag        <= 1'b0;
         bus.flag1       <= 1'b0;
      end else begin
         bus.ctrl_valid <= xfer;
         bus.illegal    <= xfer & d_ill;
         if (xfer) begin
            bus.alucode     <= ALU_W'(d_alu);
            bus.imControl   <= d_im;
            bus.writecode   <= d_wr;
            bus.pcControl   <= d_pc;
            bus.stackSelect <= d_stk;
            bus.op1         <= bus.instr[INSTR_W-OPC_W-2 -: REG_W];
            bus.op2         <= bus.instr[IMM_W-1:0];
            bus.flag        <= bus.instr[INSTR_W-OPC_W-1];
            bus.flag1       <= bus.instr[IMM_W];
         end else if (clear) begin
            bus.alucode     <= '0;
            bus.imControl   <= 1'b0;
            bus.writecode   <= 1'b0;
            bus.pcControl   <= '0;
            bus.stackSelect <= '0;
            bus.op1         <= '0;
            bus.op2         <= '0;
            bus.flag        <= 1'b0;
            bus.flag1       <= 1'b0;
         end else if (state == ST_EXEC && cur_hlt) begin
            // HLT decode already leaves only pcControl=HLT; drop its operand fields on entry to HALT
            bus.op1   <= '0;
            bus.op2   <= '0;
            bus.flag  <= 1'b0;
            bus.flag1 <= 1'b0;
         end
      end
   end
endmodule
